// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM states: idle, fetch granted, load/store granted.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } arb_state_e;

  // Requester indices; also the encoding of the round-robin pointer.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/return signals and the single memory bus, bundled.
// slave: the arbiter's view. master: the environment (core plus memory).
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ifReq;
  logic [ADDR_WIDTH-1:0] ifAddr;
  logic                  dataReq;
  logic                  dataWe;
  logic [ADDR_WIDTH-1:0] dataAddr;
  logic [DATA_WIDTH-1:0] dataWdata;
  logic [DATA_WIDTH-1:0] instr;
  logic                  ifValid;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  memValid;
  logic                  busErr;
  logic                  memReq;
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic [DATA_WIDTH-1:0] memRdata;
  logic                  memAck;

  modport slave (
    input  ifReq, ifAddr, dataReq, dataWe, dataAddr, dataWdata, memRdata, memAck,
    output instr, ifValid, dataIn, memValid, busErr, memReq, memWe, memAddr, memWdata
  );

  modport master (
    output ifReq, ifAddr, dataReq, dataWe, dataAddr, dataWdata, memRdata, memAck,
    input  instr, ifValid, dataIn, memValid, busErr, memReq, memWe, memAddr, memWdata
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Grant-cycle watchdog: counts cycles a transaction waits for memAck and
// flags the last allowed cycle. TIMEOUT_CYCLES = 0 disables it.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  // Cleared while idle so every grant starts from zero; counts unacknowledged cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the last grant cycle, so the bus request drops after TIMEOUT_CYCLES cycles.
  always_comb begin
    timeout = (TIMEOUT_CYCLES != 0) && en && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One bus transaction at a time, registered bus outputs and return data,
// one-cycle valid pulses, watchdog abort with sticky busErr.
// Optional: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on
// collisions; otherwise load/store has fixed priority over fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic                  if_valid_q, if_valid_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  bus_err_q, bus_err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  rr_q, rr_d;
`endif

  logic                  if_pend, data_pend, sel, timeout, wd_clr, wd_en;
  logic [DATA_WIDTH-1:0] ret_word;

  // Watchdog runs only while granted and waiting.
  assign wd_clr = (state_q == StIdle);
  assign wd_en  = (state_q != StIdle) && !bus.memAck;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .timeout(timeout)
  );

  // Requester selection; a request whose valid is pulsing now is stale.
  always_comb begin
    if_pend   = bus.ifReq && !if_valid_q;
    data_pend = bus.dataReq && !mem_valid_q;
    sel       = REQ_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (if_pend && data_pend) begin
      sel = rr_q;
    end else if (if_pend) begin
      sel = REQ_I;
    end
`else
    if (!data_pend) begin
      sel = REQ_I;
    end
`endif
  end

  // Next-state and registered outputs; bus outputs hold unless changed.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    instr_d     = instr_q;
    data_in_d   = data_in_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    bus_err_d   = bus_err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif
    // An abort returns zero; ack wins over a coincident timeout.
    ret_word    = bus.memAck ? bus.memRdata : '0;

    unique case (state_q)
      StIdle: begin
        if (if_pend || data_pend) begin
          mem_req_d = 1'b1;
          if (sel == REQ_I) begin
            state_d    = StGntI;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.ifAddr;
          end else begin
            state_d     = StGntD;
            mem_we_d    = bus.dataWe;
            mem_addr_d  = bus.dataAddr;
            mem_wdata_d = bus.dataWdata;
          end
        end else begin
          mem_req_d = 1'b0;
        end
      end
      StGntI, StGntD: begin
        if (bus.memAck || timeout) begin
          mem_req_d = 1'b0;
          state_d   = StIdle;
          if (!bus.memAck) begin
            bus_err_d = 1'b1;
          end
          if (state_q == StGntI) begin
            instr_d    = ret_word;
            if_valid_d = 1'b1;
          end else begin
            data_in_d   = ret_word;
            mem_valid_d = 1'b1;
          end
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d = (state_q == StGntI) ? REQ_D : REQ_I;
`endif
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State register; reset drops memReq immediately and loses any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      instr_q     <= '0;
      data_in_q   <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      bus_err_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= REQ_I;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      instr_q     <= instr_d;
      data_in_q   <= data_in_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      bus_err_q   <= bus_err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign bus.memReq   = mem_req_q;
  assign bus.memWe    = mem_we_q;
  assign bus.memAddr  = mem_addr_q;
  assign bus.memWdata = mem_wdata_q;
  assign bus.instr    = instr_q;
  assign bus.dataIn   = data_in_q;
  assign bus.ifValid  = if_valid_q;
  assign bus.memValid = mem_valid_q;
  assign bus.busErr   = bus_err_q;
endmodule
